delay_line_scan_ctrl: RTL and testbench



---
 rtl/delay_line_scan_ctrl_pkg.sv | 24 ++
 rtl/delay_line_scan_ctrl_scan_coord_counter.sv | 46 ++++
 rtl/delay_line_scan_ctrl.sv | 143 ++++++++++++++
 tb/tb_delay_line_scan_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/delay_line_scan_ctrl_pkg.sv
// Shared types and helpers for the SGM delay-line scan controller.
// Holds the scan FSM encoding and the width helper used to size coordinate/tick counters.
package delay_line_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2
  } scan_state_t;

  // Bits needed to hold values 0..value-1, never less than one.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = (value > 1) ? value - 1 : 0;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/delay_line_scan_ctrl_scan_coord_counter.sv
// Raster col/row wrap counter with border flags and a last-pixel flag.
// Outputs describe the pixel consumed by the next enabled cycle.
module scan_coord_counter
  import delay_line_scan_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH  = 640,
  parameter int unsigned HEIGHT = 480,
  localparam int unsigned COL_BITS = clog2(WIDTH),
  localparam int unsigned ROW_BITS = clog2(HEIGHT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  output logic [COL_BITS-1:0] col,
  output logic [ROW_BITS-1:0] row,
  output logic                first_col,
  output logic                last_col,
  output logic                first_row,
  output logic                last_row,
  output logic                last_pix
);

  localparam logic [COL_BITS-1:0] COL_MAX = COL_BITS'(WIDTH - 1);
  localparam logic [ROW_BITS-1:0] ROW_MAX = ROW_BITS'(HEIGHT - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (en) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + ROW_BITS'(1);
      end else begin
        col <= col + COL_BITS'(1);
      end
    end
  end

  assign first_col = (col == '0);
  assign last_col  = (col == COL_MAX);
  assign first_row = (row == '0);
  assign last_row  = (row == ROW_MAX);
  assign last_pix  = last_col & last_row;

endmodule

// File: rtl/delay_line_scan_ctrl.sv
// Delay-line sequencer: accepts a raster stream, drives shared ce/rst strobes, flushes at frame end.
// Optional sticky protocol checker enabled by defining SCAN_PROTOCOL_CHECK_EN.
module delay_line_scan_ctrl
  import delay_line_scan_ctrl_pkg::*;
#(
  parameter int unsigned IMG_WIDTH    = 640,
  parameter int unsigned IMG_HEIGHT   = 480,
  parameter int unsigned PIPE_LATENCY = 8,
  localparam int unsigned COL_BITS = clog2(IMG_WIDTH),
  localparam int unsigned ROW_BITS = clog2(IMG_HEIGHT),
  localparam int unsigned CNT_BITS = clog2(IMG_WIDTH * IMG_HEIGHT + PIPE_LATENCY + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pix_valid_in,
  input  logic                sof_in,
  output logic                in_ready,
  output logic                line_ce,
  output logic                line_rst,
  output logic [COL_BITS-1:0] col,
  output logic [ROW_BITS-1:0] row,
  output logic                first_col,
  output logic                last_col,
  output logic                first_row,
  output logic                last_row,
  output logic                out_valid,
  output logic                out_eof,
  output logic                frame_done,
  output logic                busy,
  output logic                err_protocol
);

  localparam logic [CNT_BITS-1:0] EOF_TICK   = CNT_BITS'(IMG_WIDTH * IMG_HEIGHT + PIPE_LATENCY - 1);
  localparam logic [CNT_BITS-1:0] FLUSH_LOAD = CNT_BITS'(PIPE_LATENCY);

  scan_state_t         state, state_nxt;
  logic [CNT_BITS-1:0] flush_cnt, flush_cnt_nxt;
  logic [CNT_BITS-1:0] ce_cnt;
  logic                accept;
  logic                flush_ce;
  logic                last_pix;

  scan_coord_counter #(
    .WIDTH  (IMG_WIDTH),
    .HEIGHT (IMG_HEIGHT)
  ) u_coord (
    .clk       (clk),
    .rst       (rst),
    .en        (accept),
    .col       (col),
    .row       (row),
    .first_col (first_col),
    .last_col  (last_col),
    .first_row (first_row),
    .last_row  (last_row),
    .last_pix  (last_pix)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    in_ready      = 1'b0;
    accept        = 1'b0;
    flush_ce      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        accept   = pix_valid_in & sof_in;
        if (accept) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        in_ready = 1'b1;
        accept   = pix_valid_in;
        if (accept && last_pix) begin
          if (PIPE_LATENCY == 0) begin
            state_nxt = IDLE;
          end else begin
            state_nxt     = FLUSH;
            flush_cnt_nxt = FLUSH_LOAD;
          end
        end
      end
      FLUSH: begin
        flush_ce      = 1'b1;
        flush_cnt_nxt = flush_cnt - CNT_BITS'(1);
        if (flush_cnt == CNT_BITS'(1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Gated by rst so the enable collapses the moment reset is raised, not at the next edge.
  assign line_ce  = (accept | flush_ce) & ~rst;
  assign out_eof  = line_ce & (ce_cnt == EOF_TICK);
  assign line_rst = out_eof;
  assign busy     = (state != IDLE);

  generate
    if (PIPE_LATENCY == 0) begin : g_no_latency
      assign out_valid = line_ce;
    end else begin : g_latency
      assign out_valid = line_ce & (ce_cnt >= FLUSH_LOAD);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ce_cnt     <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= out_eof;
      if (out_eof)      ce_cnt <= '0;
      else if (line_ce) ce_cnt <= ce_cnt + CNT_BITS'(1);
    end
  end

`ifdef SCAN_PROTOCOL_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (pix_valid_in && (((state == IDLE) && !sof_in) || ((state == ACTIVE) && sof_in))) begin
      err_q <= 1'b1;
    end
  end

  assign err_protocol = err_q;
`else
  assign err_protocol = 1'b0;
`endif

endmodule

// File: tb/tb_delay_line_scan_ctrl.sv
// Scoreboard bench for delay_line_scan_ctrl: W4/H3/L5 instance and a W2/H2/L0 instance.
`timescale 1ns/1ps
module tb_delay_line_scan_ctrl;

  localparam int unsigned AW = 4, AH = 3, AL = 5;
  localparam int unsigned BW = 2, BH = 2, BL = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       a_v, a_s, a_ready, a_ce, a_lrst, a_fc, a_lc, a_fr, a_lr, a_ov, a_eof, a_fd, a_busy, a_err;
  logic [1:0] a_col, a_row;
  logic       b_v, b_s, b_ready, b_ce, b_lrst, b_fc, b_lc, b_fr, b_lr, b_ov, b_eof, b_fd, b_busy, b_err;
  logic [0:0] b_col, b_row;

  delay_line_scan_ctrl #(.IMG_WIDTH(AW), .IMG_HEIGHT(AH), .PIPE_LATENCY(AL)) dut_a (
    .clk(clk), .rst(rst), .pix_valid_in(a_v), .sof_in(a_s), .in_ready(a_ready),
    .line_ce(a_ce), .line_rst(a_lrst), .col(a_col), .row(a_row),
    .first_col(a_fc), .last_col(a_lc), .first_row(a_fr), .last_row(a_lr),
    .out_valid(a_ov), .out_eof(a_eof), .frame_done(a_fd), .busy(a_busy), .err_protocol(a_err)
  );

  delay_line_scan_ctrl #(.IMG_WIDTH(BW), .IMG_HEIGHT(BH), .PIPE_LATENCY(BL)) dut_b (
    .clk(clk), .rst(rst), .pix_valid_in(b_v), .sof_in(b_s), .in_ready(b_ready),
    .line_ce(b_ce), .line_rst(b_lrst), .col(b_col), .row(b_row),
    .first_col(b_fc), .last_col(b_lc), .first_row(b_fr), .last_row(b_lr),
    .out_valid(b_ov), .out_eof(b_eof), .frame_done(b_fd), .busy(b_busy), .err_protocol(b_err)
  );

  // View of whichever instance is under test
  int   sel = 0;
  logic m_ce, m_lrst, m_fc, m_lc, m_fr, m_lr, m_ov, m_eof, m_fd, m_busy, m_err, m_ready;
  int   m_col, m_row;
  assign m_ce    = (sel == 1) ? b_ce    : a_ce;
  assign m_lrst  = (sel == 1) ? b_lrst  : a_lrst;
  assign m_fc    = (sel == 1) ? b_fc    : a_fc;
  assign m_lc    = (sel == 1) ? b_lc    : a_lc;
  assign m_fr    = (sel == 1) ? b_fr    : a_fr;
  assign m_lr    = (sel == 1) ? b_lr    : a_lr;
  assign m_ov    = (sel == 1) ? b_ov    : a_ov;
  assign m_eof   = (sel == 1) ? b_eof   : a_eof;
  assign m_fd    = (sel == 1) ? b_fd    : a_fd;
  assign m_busy  = (sel == 1) ? b_busy  : a_busy;
  assign m_err   = (sel == 1) ? b_err   : a_err;
  assign m_ready = (sel == 1) ? b_ready : a_ready;
  assign m_col   = (sel == 1) ? int'(b_col) : int'(a_col);
  assign m_row   = (sel == 1) ? int'(b_row) : int'(a_row);

  typedef struct {
    bit ce;
    bit fd;
    int col;
    int row;
    bit ov;
    bit eof;
  } rec_t;

  rec_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;

  // Reference model: frame as a sequence of ticks; pixel p is at (p%W, p/W)
  typedef enum {M_IDLE, M_ACTIVE, M_FLUSH} mmode_t;
  mmode_t m_mode;
  int     mw = AW, mh = AH, ml = AL;
  int     m_pix, m_tick, m_flush;
  bit     m_fd_pend, m_err_exp;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_err();
`ifdef SCAN_PROTOCOL_CHECK_EN
    return int'(m_err_exp);
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_mode    = M_IDLE;
    m_pix     = 0;
    m_tick    = 0;
    m_flush   = 0;
    m_fd_pend = 1'b0;
    m_err_exp = 1'b0;
  endtask

  task automatic drive(input bit v, input bit s);
    if (sel == 1) begin b_v = v; b_s = s; end
    else          begin a_v = v; a_s = s; end
  endtask

  // One clock of stimulus: predict, push expectation, check handshake, advance.
  task automatic step(input bit v, input bit s);
    rec_t r;
    bit   acc;
    int   exp_ready, exp_busy;
    drive(v, s);
    r = '{ce: 1'b0, fd: m_fd_pend, col: 0, row: 0, ov: 1'b0, eof: 1'b0};
    m_fd_pend = 1'b0;
    exp_ready = (m_mode != M_FLUSH) ? 1 : 0;
    exp_busy  = (m_mode != M_IDLE) ? 1 : 0;
    acc = 1'b0;
    case (m_mode)
      M_IDLE:   if (v && s) acc = 1'b1; else if (v) m_err_exp = 1'b1;
      M_ACTIVE: if (v) begin acc = 1'b1; if (s) m_err_exp = 1'b1; end
      default:  r.ce = 1'b1;
    endcase
    if (acc) begin
      r.ce   = 1'b1;
      r.col  = m_pix % mw;
      r.row  = m_pix / mw;
      m_pix  = m_pix + 1;
      m_mode = M_ACTIVE;
    end
    if (r.ce) begin
      r.ov   = (m_tick >= ml);
      r.eof  = (m_tick == mw * mh + ml - 1);
      m_tick = m_tick + 1;
    end
    if (acc && m_pix == mw * mh) begin
      m_mode  = (ml == 0) ? M_IDLE : M_FLUSH;
      m_flush = ml;
    end else if (m_mode == M_FLUSH && !acc) begin
      m_flush = m_flush - 1;
      if (m_flush == 0) m_mode = M_IDLE;
    end
    if (r.eof) begin
      m_fd_pend = 1'b1;
      m_tick    = 0;
      m_pix     = 0;
    end
    if (r.ce || r.fd) exp_q.push_back(r);
    @(negedge clk);
    check("in_ready", int'(m_ready), exp_ready);
    check("busy", int'(m_busy), exp_busy);
    @(posedge clk);
    #1;
  endtask

  // vmode 0: continuous valid; 1: alternating valid; 2: random valid with stray sof
  task automatic finish_frame(input int vmode);
    bit v, s;
    for (int i = 0; i < 400 && m_mode != M_IDLE; i++) begin
      s = 1'b0;
      case (vmode)
        0:       v = 1'b1;
        1:       v = (i % 2 == 1);
        default: begin v = ($urandom % 4) != 0; s = ($urandom % 8) == 0; end
      endcase
      step(v, s);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b1, 1'b1);
    #1;
    check("rst_line_ce", int'(m_ce), 0);
    check("rst_busy", int'(m_busy), 0);
    check("rst_col", m_col, 0);
    check("rst_row", m_row, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 1'b0);
  endtask

  rec_t mon_r;
  always @(negedge clk) begin
    if (mon_en && (m_ce || m_fd)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", 1, 0);
      end else begin
        mon_r = exp_q.pop_front();
        check("line_ce", int'(m_ce), int'(mon_r.ce));
        check("frame_done", int'(m_fd), int'(mon_r.fd));
        if (mon_r.ce) begin
          check("col", m_col, mon_r.col);
          check("row", m_row, mon_r.row);
          check("first_col", int'(m_fc), int'(mon_r.col == 0));
          check("last_col", int'(m_lc), int'(mon_r.col == mw - 1));
          check("first_row", int'(m_fr), int'(mon_r.row == 0));
          check("last_row", int'(m_lr), int'(mon_r.row == mh - 1));
          check("out_valid", int'(m_ov), int'(mon_r.ov));
          check("out_eof", int'(m_eof), int'(mon_r.eof));
          check("line_rst", int'(m_lrst), int'(mon_r.eof));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    a_v = 1'b0; a_s = 1'b0; b_v = 1'b0; b_s = 1'b0;
    model_reset();
    #2;
    check("reset_line_ce", int'(a_ce), 0);
    check("reset_busy", int'(a_busy), 0);
    check("reset_col", int'(a_col), 0);
    check("reset_row", int'(a_row), 0);
    check("reset_frame_done", int'(a_fd), 0);
    check("reset_err", int'(a_err), 0);
    check("reset_in_ready", int'(a_ready), 1);
    check("reset_first_col", int'(a_fc), 1);
    check("reset_b_line_ce", int'(b_ce), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // Continuous frame, then a frame with alternating bubbles
    step(1'b1, 1'b1);
    finish_frame(0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    finish_frame(1);
    step(1'b0, 1'b0);

    // sof held through FLUSH, re-accepted in the frame_done cycle
    step(1'b1, 1'b1);
    while (m_mode == M_ACTIVE) step(1'b1, 1'b0);
    while (m_mode == M_FLUSH) step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    finish_frame(0);
    step(1'b0, 1'b0);
    check("err_after_clean", int'(m_err), exp_err());

    // Valid without sof while idle
    repeat (3) step(1'b1, 1'b0);
    check("idle_col", m_col, 0);
    check("err_after_idle_valid", int'(m_err), exp_err());

    // Reset mid-frame after 7 accepts
    step(1'b1, 1'b1);
    repeat (6) step(1'b1, 1'b0);
    do_reset();
    check("err_after_rst", int'(m_err), 0);
    step(1'b1, 1'b1);
    finish_frame(0);
    step(1'b0, 1'b0);

    // Random frames with random gaps and stray sof
    for (int f = 0; f < 3; f++) begin
      repeat ($urandom_range(0, 3)) step(1'(($urandom % 2) == 0), 1'b0);
      step(1'b1, 1'b1);
      finish_frame(2);
    end
    step(1'b0, 1'b0);
    check("err_random", int'(m_err), exp_err());

    // Zero-latency instance
    sel = 1; mw = BW; mh = BH; ml = BL;
    model_reset();
    step(1'b1, 1'b1);
    repeat (3) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    finish_frame(2);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    check("queue_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
